// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with sign handling.
// Results are published only on completion so downstream displays never show partial digits.
module bin2bcd_seq #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DIGITS    = 5,
    parameter int unsigned SIGNED_IN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  sign_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic [1:0]            dbg_state_o
);
    // Handshake: start is a request sampled on every rising edge but accepted only in
    // IDLE (no queuing); done is a single-cycle pulse from which bcd_out/sign_out are valid.
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FINISH = 2'd2} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic [4*DIGITS-1:0] scratch_q, scratch_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [4*DIGITS-1:0] corrected;
    logic                sign_q, sign_d;
    logic                sign_out_q, sign_out_d;
    logic [WIDTH-1:0]    in_mag;
    logic                in_neg;

    // Two's complement magnitude: the most negative value maps onto its unsigned bit pattern.
    always_comb begin
        in_neg = sign_in;
        in_mag = bin_in;
        if (SIGNED_IN != 0) begin
            in_neg = bin_in[WIDTH-1];
            in_mag = bin_in[WIDTH-1] ? (~bin_in + 1'b1) : bin_in;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DIGITS); i++) begin
            corrected[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                                : scratch_q[4*i +: 4];
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mag_d      = mag_q;
        scratch_d  = scratch_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        sign_out_d = sign_out_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mag_d     = in_mag;
                    scratch_d = '0;
                    count_d   = CW'(WIDTH);
                    sign_d    = in_neg && (in_mag != '0);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {corrected[4*DIGITS-2:0], mag_q[WIDTH-1]};
                mag_d     = {mag_q[WIDTH-2:0], 1'b0};
                count_d   = count_q - 1'b1;
                // The last shift publishes straight into the output register so the
                // values are already valid in the cycle that done is high.
                if (count_q == CW'(1)) begin
                    bcd_d      = scratch_d;
                    sign_out_d = sign_q;
                    state_d    = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            mag_q      <= '0;
            scratch_q  <= '0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            sign_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mag_q      <= mag_d;
            scratch_q  <= scratch_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            sign_out_q <= sign_out_d;
        end
    end

    assign busy        = (state_q == SHIFT);
    assign done        = (state_q == FINISH);
    assign bcd_out     = bcd_q;
    assign sign_out    = sign_out_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: unsigned and signed instances driven with identical stimulus.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        sign_in = 1'b0;
    logic        busy, done, sign_u;
    logic        busy_s, done_s, sign_s;
    logic [19:0] bcd_u, bcd_s;
    logic [1:0]  dbg_u, dbg_s;

    int n_checks = 0;
    int n_errors = 0;
    logic [20:0] exp_q[$];
    logic [20:0] exp_s_q[$];

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED_IN(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in), .sign_in(sign_in),
        .busy(busy), .done(done), .bcd_out(bcd_u), .sign_out(sign_u), .dbg_state_o(dbg_u));

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED_IN(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in), .sign_in(sign_in),
        .busy(busy_s), .done(done_s), .bcd_out(bcd_s), .sign_out(sign_s), .dbg_state_o(dbg_s));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain decimal arithmetic
    function automatic logic [19:0] to_bcd(input int unsigned m);
        logic [19:0] r;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [20:0] ref_u(input logic [15:0] v, input logic s);
        int unsigned m = v;
        return {s && (m != 0), to_bcd(m)};
    endfunction

    function automatic logic [20:0] ref_s(input logic [15:0] v);
        int unsigned m = v[15] ? (65536 - int'(v)) : v;
        return {v[15] && (m != 0), to_bcd(m)};
    endfunction

    task automatic run_conv(input logic [15:0] v, input logic s, input logic [20:0] eu,
                            input logic [20:0] es, input string tag);
        int edges;
        int busy_cyc;
        @(negedge clk);
        start = 1'b1; bin_in = v; sign_in = s;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; bin_in = 16'($urandom); sign_in = 1'($urandom);
        edges = 0; busy_cyc = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk); edges++;
            @(negedge clk);
            bin_in = 16'($urandom); sign_in = 1'($urandom);
        end
        chk({tag, ".latency"}, edges, 16);
        chk({tag, ".busy_cycles"}, busy_cyc, 16);
        chk({tag, ".busy_at_done"}, {31'd0, busy}, 0);
        chk({tag, ".done_s"}, {31'd0, done_s}, 1);
        chk({tag, ".unsigned"}, {11'd0, sign_u, bcd_u}, {11'd0, eu});
        chk({tag, ".signed"}, {11'd0, sign_s, bcd_s}, {11'd0, es});
        @(negedge clk);
        chk({tag, ".done_drop"}, {31'd0, done}, 0);
        chk({tag, ".hold"}, {11'd0, sign_u, bcd_u}, {11'd0, eu});
    endtask

    typedef struct {
        logic [15:0] v;
        logic        s;
        logic [20:0] eu;
        logic [20:0] es;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16'h0000, 1'b0, {1'b0, 20'h00000}, {1'b0, 20'h00000}};
        vecs[1] = '{16'hFFFF, 1'b1, {1'b1, 20'h65535}, {1'b1, 20'h00001}};
        vecs[2] = '{16'h0000, 1'b1, {1'b0, 20'h00000}, {1'b0, 20'h00000}};
        vecs[3] = '{16'h8000, 1'b0, {1'b0, 20'h32768}, {1'b1, 20'h32768}};
        vecs[4] = '{16'h7FFF, 1'b1, {1'b1, 20'h32767}, {1'b0, 20'h32767}};
        vecs[5] = '{16'h04D2, 1'b0, {1'b0, 20'h01234}, {1'b0, 20'h01234}};
        vecs[6] = '{16'h0009, 1'b0, {1'b0, 20'h00009}, {1'b0, 20'h00009}};
        vecs[7] = '{16'h000A, 1'b1, {1'b1, 20'h00010}, {1'b0, 20'h00010}};
        vecs[8] = '{16'hFF9C, 1'b0, {1'b0, 20'h65436}, {1'b1, 20'h00100}};

        // Reset state
        #1;
        chk("reset.busy", {31'd0, busy}, 0);
        chk("reset.done", {31'd0, done}, 0);
        chk("reset.bcd", {11'd0, sign_u, bcd_u}, 0);
        chk("reset.bcd_s", {11'd0, sign_s, bcd_s}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_conv(vecs[i].v, vecs[i].s, vecs[i].eu, vecs[i].es, $sformatf("vec%0d", i));

        for (int i = 0; i < 25; i++) begin
            logic [15:0] v;
            logic        s;
            v = 16'($urandom);
            if (i % 5 == 0) v = 16'($urandom_range(0, 99));
            s = 1'($urandom);
            run_conv(v, s, ref_u(v, s), ref_s(v), $sformatf("rnd%0d", i));
        end

        // start held continuously with bin_in changing every cycle
        begin
            int          rem;
            logic [20:0] prev_u;
            logic [20:0] got;
            rem = 0;
            prev_u = {sign_u, bcd_u};
            @(negedge clk);
            start = 1'b1; bin_in = 16'($urandom); sign_in = 1'($urandom);
            for (int cyc = 0; cyc < 60; cyc++) begin
                @(posedge clk);
                if (rem == 0 && start) begin
                    exp_q.push_back(ref_u(bin_in, sign_in));
                    exp_s_q.push_back(ref_s(bin_in));
                    rem = 17;
                end else if (rem > 0) begin
                    rem--;
                end
                @(negedge clk);
                chk("hold.done", {31'd0, done}, {31'd0, rem == 1});
                chk("hold.busy", {31'd0, busy}, {31'd0, rem >= 2});
                if (done) begin
                    if (exp_q.size() == 0 || exp_s_q.size() == 0) begin
                        chk("hold.unexpected_done", 1, 0);
                    end else begin
                        got = exp_q.pop_front();
                        chk("hold.result", {11'd0, sign_u, bcd_u}, {11'd0, got});
                        got = exp_s_q.pop_front();
                        chk("hold.result_s", {11'd0, sign_s, bcd_s}, {11'd0, got});
                    end
                end else begin
                    chk("hold.stable", {11'd0, sign_u, bcd_u}, {11'd0, prev_u});
                end
                prev_u = {sign_u, bcd_u};
                if (cyc < 39) begin
                    bin_in = 16'($urandom); sign_in = 1'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
            chk("hold.queue_empty", exp_q.size(), 0);
        end

        // Reset in the middle of a conversion
        run_conv(16'hFFFF, 1'b1, {1'b1, 20'h65535}, {1'b1, 20'h00001}, "pre_rst");
        begin
            int seen_done;
            seen_done = 0;
            @(negedge clk);
            start = 1'b1; bin_in = 16'd1234; sign_in = 1'b0;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            repeat (8) @(posedge clk);
            @(negedge clk);
            chk("rst_mid.busy_before", {31'd0, busy}, 1);
            rst_n = 1'b0;
            #1;
            chk("rst_mid.busy", {31'd0, busy}, 0);
            chk("rst_mid.done", {31'd0, done}, 0);
            chk("rst_mid.bcd", {11'd0, sign_u, bcd_u}, 0);
            chk("rst_mid.bcd_s", {11'd0, sign_s, bcd_s}, 0);
            repeat (12) begin
                @(negedge clk);
                if (done) seen_done++;
            end
            chk("rst_mid.no_done", seen_done, 0);
            rst_n = 1'b1;
        end
        run_conv(16'd1234, 1'b0, {1'b0, 20'h01234}, {1'b0, 20'h01234}, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
